if_icache: RTL and testbench

- Next-generation instruction-fetch stage with a parametrised set-associative I-cache (SETS x WAYS x LINE_WORDS).
- Multi-word lines are refilled by a burst-style refill FSM over the single-word memory port.
- Supports a flush input for fence.i and a full-cache invalidate.
- Sits between the PC register and IF/ID. Hits return combinationally in the lookup cycle; misses stall the front end until the line is resident.

---
 rtl/if_icache_pkg.sv | 34 +++
 rtl/if_icache_way.sv | 53 +++++
 rtl/if_icache.sv | 200 ++++++++++++++++++++
 tb/tb_if_icache.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/if_icache_pkg.sv
// Shared constants, state encoding and address field helpers for the fetch-stage I-cache.
package if_icache_pkg;

    localparam int unsigned ADDR_W_DEF     = 32;
    localparam int unsigned SETS_DEF       = 64;
    localparam int unsigned WAYS_DEF       = 2;
    localparam int unsigned LINE_WORDS_DEF = 4;

    localparam int unsigned OFF_W = $clog2(LINE_WORDS_DEF);
    localparam int unsigned IDX_W = $clog2(SETS_DEF);
    localparam int unsigned TAG_W = ADDR_W_DEF - IDX_W - OFF_W - 2;

    typedef enum logic [0:0] {StIdle, StRefill} state_e;

    // Helpers work on a zero-extended 64-bit address so any ADDR_W up to 64 fits.
    function automatic logic [63:0] line_base(input logic [63:0] addr, input int unsigned off_w);
        return (addr >> (off_w + 2)) << (off_w + 2);
    endfunction

    function automatic logic [63:0] addr_off(input logic [63:0] addr, input int unsigned off_w);
        return (addr >> 2) & ((64'd1 << off_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_idx(input logic [63:0] addr, input int unsigned off_w,
                                             input int unsigned idx_w);
        return (addr >> (off_w + 2)) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int unsigned off_w,
                                             input int unsigned idx_w);
        return addr >> (off_w + idx_w + 2);
    endfunction

endpackage

// File: rtl/if_icache_way.sv
// One cache way: per-set valid bit, tag and line data with a combinational read port.
module icache_way #(
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned TAG_W      = 22,
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned OFF_W      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [OFF_W-1:0] rd_off_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [OFF_W-1:0] wr_off_i,
    input  logic [31:0]      wr_data_i,
    input  logic             set_valid_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             clr_valid_i,
    input  logic [IDX_W-1:0] clr_idx_i,
    input  logic             clr_all_i
);

    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS][LINE_WORDS];

    always_comb begin
        valid_d = valid_q;
        if (clr_valid_i) valid_d[clr_idx_i] = 1'b0;
        if (set_valid_i) valid_d[wr_idx_i] = 1'b1;
        if (clr_all_i)   valid_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    // Tag and data need no reset: nothing reads them while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (wr_en_i)     data_q[wr_idx_i][wr_off_i] <= wr_data_i;
        if (set_valid_i) tag_q[wr_idx_i] <= tag_i;
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/if_icache.sv
// Instruction-fetch stage with a set-associative I-cache and a burst refill FSM.
module if_icache
    import if_icache_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned SETS       = SETS_DEF,
    parameter int unsigned WAYS       = WAYS_DEF,
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_rdy_i,
    input  logic [31:0]       inst_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       inst_o,
    output logic              if_stall
);

    localparam int unsigned OffBits = $clog2(LINE_WORDS);
    localparam int unsigned IdxBits = $clog2(SETS);
    localparam int unsigned TagBits = ADDR_W - OffBits - IdxBits - 2;
    localparam int unsigned OffW    = (OffBits > 0) ? OffBits : 1;
    localparam int unsigned IdxW    = (IdxBits > 0) ? IdxBits : 1;
    localparam int unsigned WayW    = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_e              state_q, state_d;
    logic [OffW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [TagBits-1:0]  tag_q, tag_d;
    logic [WayW-1:0]     way_q, way_d;
    logic                from_ptr_q, from_ptr_d;
    logic [WayW-1:0]     ptr_q [SETS];

    logic [63:0]         pc_ext;
    logic [IdxW-1:0]     look_idx;
    logic [OffW-1:0]     look_off;
    logic [TagBits-1:0]  look_tag;
    logic [WAYS-1:0]     way_valid, way_hit;
    logic [TagBits-1:0]  way_tag  [WAYS];
    logic [31:0]         way_data [WAYS];
    logic                hit, active;
    logic [31:0]         hit_data;
    logic [WayW-1:0]     vict_way, ptr_next;
    logic                vict_from_ptr;
    logic                wr_en, set_valid, clr_valid, clr_all, ptr_we;

    assign pc_ext   = 64'(pc_i);
    assign look_idx = IdxW'(addr_idx(pc_ext, OffBits, IdxBits));
    assign look_off = OffW'(addr_off(pc_ext, OffBits));
    assign look_tag = TagBits'(addr_tag(pc_ext, OffBits, IdxBits));
    assign active   = rdy && !rst;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS),
            .TAG_W      (TagBits),
            .IDX_W      (IdxW),
            .OFF_W      (OffW)
        ) u_way (
            .clk         (clk),
            .rst         (rst),
            .rd_idx_i    (look_idx),
            .rd_off_i    (look_off),
            .rd_valid_o  (way_valid[w]),
            .rd_tag_o    (way_tag[w]),
            .rd_data_o   (way_data[w]),
            .wr_en_i     (wr_en && (way_q == WayW'(w))),
            .wr_idx_i    (idx_q),
            .wr_off_i    (cnt_q),
            .wr_data_i   (inst_i),
            .set_valid_i (set_valid && (way_q == WayW'(w))),
            .tag_i       (tag_q),
            .clr_valid_i (clr_valid && (vict_way == WayW'(w))),
            .clr_idx_i   (look_idx),
            .clr_all_i   (clr_all)
        );
        assign way_hit[w] = way_valid[w] && (way_tag[w] == look_tag);
    end

    assign hit = $onehot(way_hit);

    // Lowest invalid way wins; the round-robin pointer is used only when the set is full.
    always_comb begin
        hit_data      = '0;
        vict_way      = ptr_q[look_idx];
        vict_from_ptr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_hit[w]) hit_data = hit_data | way_data[w];
            if (!way_valid[w]) begin
                vict_way      = WayW'(w);
                vict_from_ptr = 1'b0;
            end
        end
    end

    assign ptr_next = (WAYS == 1) ? '0 : way_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        idx_d      = idx_q;
        tag_d      = tag_q;
        way_d      = way_q;
        from_ptr_d = from_ptr_q;
        wr_en      = 1'b0;
        set_valid  = 1'b0;
        clr_valid  = 1'b0;
        clr_all    = 1'b0;
        ptr_we     = 1'b0;
        if (active) begin
            if (flush_i) begin
                clr_all = 1'b1;
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (!hit) begin
                            base_d     = ADDR_W'(line_base(pc_ext, OffBits));
                            idx_d      = look_idx;
                            tag_d      = look_tag;
                            way_d      = vict_way;
                            from_ptr_d = vict_from_ptr;
                            clr_valid  = 1'b1;
                            cnt_d      = '0;
                            state_d    = StRefill;
                        end
                    end
                    StRefill: begin
                        if (mem_rdy_i) begin
                            wr_en = 1'b1;
                            if (cnt_q == OffW'(LINE_WORDS - 1)) begin
                                set_valid = 1'b1;
                                ptr_we    = from_ptr_q;
                                cnt_d     = '0;
                                state_d   = StIdle;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            base_q     <= '0;
            idx_q      <= '0;
            tag_q      <= '0;
            way_q      <= '0;
            from_ptr_q <= 1'b0;
            for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            tag_q      <= tag_d;
            way_q      <= way_d;
            from_ptr_q <= from_ptr_d;
            if (ptr_we) ptr_q[idx_q] <= ptr_next;
        end
    end

    always_comb begin
        mem_en_o   = 1'b0;
        mem_addr_o = '0;
        if_stall   = 1'b0;
        pc_o       = '0;
        inst_o     = '0;
        if (active) begin
            pc_o = pc_i;
            if (flush_i) begin
                if_stall = 1'b1;
            end else if (state_q == StRefill) begin
                mem_en_o   = 1'b1;
                mem_addr_o = base_q + (ADDR_W'(cnt_q) << 2);
                if_stall   = 1'b1;
            end else if (hit) begin
                inst_o = hit_data;
            end else begin
                if_stall = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_icache.sv
// Directed bench for if_icache: cold miss, replacement, flush, rdy freeze, pc change, reset.
module tb_if_icache;

    logic        clk = 1'b0;
    logic        rst, rdy, flush_i, mem_rdy_i;
    logic [31:0] pc_i, inst_i;
    logic        mem_en_o, if_stall;
    logic [31:0] mem_addr_o, pc_o, inst_o;
    int          n_asrt = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    if_icache #(
        .ADDR_W     (32),
        .SETS       (64),
        .WAYS       (2),
        .LINE_WORDS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .pc_i       (pc_i),
        .flush_i    (flush_i),
        .mem_en_o   (mem_en_o),
        .mem_addr_o (mem_addr_o),
        .mem_rdy_i  (mem_rdy_i),
        .inst_i     (inst_i),
        .pc_o       (pc_o),
        .inst_o     (inst_o),
        .if_stall   (if_stall)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mem_rdy_i = 1'b0;
    endtask

    // Memory with two-cycle latency: check the request, then answer it.
    task automatic serve(input logic [31:0] a);
        cyc(); #1;
        chk("req_en", 32'(mem_en_o), 32'd1);
        chk("req_addr", mem_addr_o, a);
        chk("req_stall", 32'(if_stall), 32'd1);
        chk("req_inst0", inst_o, 32'd0);
        cyc(); #1;
        chk("req_hold", mem_addr_o, a);
        mem_rdy_i = 1'b1;
        inst_i    = word_of(a);
    endtask

    task automatic expect_hit(input logic [31:0] a);
        pc_i = a; #1;
        chk("hit_stall", 32'(if_stall), 32'd0);
        chk("hit_pc", pc_o, a);
        chk("hit_inst", inst_o, word_of(a));
        chk("hit_en", 32'(mem_en_o), 32'd0);
    endtask

    task automatic expect_miss(input logic [31:0] a);
        pc_i = a; #1;
        chk("miss_stall", 32'(if_stall), 32'd1);
        chk("miss_en", 32'(mem_en_o), 32'd0);
        chk("miss_inst", inst_o, 32'd0);
        chk("miss_pc", pc_o, a);
    endtask

    task automatic fill(input logic [31:0] a);
        expect_miss(a);
        for (int i = 0; i < 4; i++) serve((a & ~32'hF) + 32'(4 * i));
        cyc();
        expect_hit(a);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"}, 32'(mem_en_o), 32'd0);
        chk({tag, "_stall"}, 32'(if_stall), 32'd0);
        chk({tag, "_pc"}, pc_o, 32'd0);
        chk({tag, "_inst"}, inst_o, 32'd0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush_i = 1'b0; mem_rdy_i = 1'b0;
        inst_i = '0; pc_i = 32'h100;
        cyc(); cyc(); #1;
        chk_zero("rst");
        chk("rst_addr", mem_addr_o, 32'd0);
        cyc(); rst = 1'b0;

        // Cold miss, then a second word of the same line hits at once
        fill(32'h100);
        cyc(); expect_hit(32'h10C);

        // Set 0 conflict: 0x000 -> way0, 0x400 -> way1, 0x800 evicts way0 (pointer 0 -> 1)
        cyc(); fill(32'h000);
        cyc(); fill(32'h400);
        cyc(); fill(32'h800);
        cyc(); expect_hit(32'h404);
        cyc(); expect_hit(32'h800);
        cyc(); fill(32'h000);
        cyc(); expect_miss(32'h400);
        expect_hit(32'h808);

        // Flush after the second response aborts the refill
        cyc(); expect_miss(32'h200);
        serve(32'h200);
        serve(32'h204);
        cyc(); flush_i = 1'b1; #1;
        chk("flush_stall", 32'(if_stall), 32'd1);
        chk("flush_en", 32'(mem_en_o), 32'd0);
        cyc(); flush_i = 1'b0;
        expect_miss(32'h200);
        serve(32'h200);

        // rdy low freezes everything, stray responses are ignored
        for (int i = 0; i < 5; i++) begin
            cyc(); rdy = 1'b0; mem_rdy_i = 1'b1; inst_i = 32'hDEAD_BEEF; #1;
            chk_zero("frz");
        end
        cyc(); rdy = 1'b1; #1;
        chk("resume_en", 32'(mem_en_o), 32'd1);
        chk("resume_addr", mem_addr_o, 32'h204);
        serve(32'h204);
        serve(32'h208);
        serve(32'h20C);
        cyc(); expect_hit(32'h200);
        cyc(); expect_hit(32'h204);
        cyc(); fill(32'h100);

        // pc change mid-refill is ignored until the line completes
        cyc(); expect_miss(32'h300);
        serve(32'h300);
        pc_i = 32'h100;
        serve(32'h304);
        chk("pcchg_pc", pc_o, 32'h100);
        serve(32'h308);
        serve(32'h30C);
        cyc(); expect_hit(32'h100);
        cyc(); expect_hit(32'h308);

        // Reset mid-refill
        cyc(); expect_miss(32'h500);
        serve(32'h500);
        cyc(); rst = 1'b1; #1;
        chk_zero("rstmid");
        cyc(); rst = 1'b0;
        expect_miss(32'h100);
        cyc(); #1;
        chk("rst_refill_en", 32'(mem_en_o), 32'd1);
        chk("rst_refill_addr", mem_addr_o, 32'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
